// File: rtl/vga_scanout_controller.sv
// VGA scan-out stage: 640x480@60 timing, 2x upscaled frame-buffer addressing,
// RGB565 to 4:4:4 conversion and vblank-only display-buffer swapping.
module vga_scanout_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int RD_LAT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        swap_req,
    input  logic [15:0] pixel_in,
    output logic [16:0] read_addr,
    output logic        display_buffer,
    output logic        swap_ack,
    output logic        frame_start,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic        vga_de,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int L       = RD_LAT + 2;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VISEND = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VISEND = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_count;
    logic [VW-1:0] v_count;
    logic          visible;
    logic          hsync_n;
    logic          vsync_n;
    logic          swap_point;
    logic          swap_pending;
    logic [16:0]   row_y;
    logic [16:0]   col_x;
    logic [16:0]   addr_next;
    logic [L-1:0]  de_pipe;
    logic [L-1:0]  hs_pipe;
    logic [L-1:0]  vs_pipe;
    logic          unused_pixel_bits;

    always_ff @(posedge clk) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
        end else begin
            h_count <= h_count + 1'b1;
        end
    end

    // Each source pixel covers a 2x2 block; row stride 320 built as y*256 + y*64.
    always_comb begin
        visible    = (h_count < H_VISEND) && (v_count < V_VISEND);
        hsync_n    = !((h_count >= HS_START) && (h_count < HS_END));
        vsync_n    = !((v_count >= VS_START) && (v_count < VS_END));
        swap_point = (h_count == '0) && (v_count == V_VISEND);
        row_y      = 17'(v_count >> 1);
        col_x      = 17'(h_count >> 1);
        addr_next  = (row_y << 8) + (row_y << 6) + col_x;
    end

    assign frame_start = !reset && (h_count == '0) && (v_count == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            read_addr <= '0;
            de_pipe   <= '0;
            hs_pipe   <= '1;
            vs_pipe   <= '1;
            vga_r     <= '0;
            vga_g     <= '0;
            vga_b     <= '0;
        end else begin
            read_addr <= visible ? addr_next : '0;
            de_pipe   <= {de_pipe[L-2:0], visible};
            hs_pipe   <= {hs_pipe[L-2:0], hsync_n};
            vs_pipe   <= {vs_pipe[L-2:0], vsync_n};
            // de_pipe[L-2] is the enable that travelled alongside this pixel_in.
            vga_r     <= de_pipe[L-2] ? pixel_in[15:12] : 4'h0;
            vga_g     <= de_pipe[L-2] ? pixel_in[10:7]  : 4'h0;
            vga_b     <= de_pipe[L-2] ? pixel_in[4:1]   : 4'h0;
        end
    end

    assign vga_de    = de_pipe[L-1];
    assign vga_hsync = hs_pipe[L-1];
    assign vga_vsync = vs_pipe[L-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            swap_pending   <= 1'b0;
            display_buffer <= 1'b0;
            swap_ack       <= 1'b0;
        end else begin
            swap_ack <= 1'b0;
            if (swap_point && (swap_pending || swap_req)) begin
                display_buffer <= ~display_buffer;
                swap_ack       <= 1'b1;
                swap_pending   <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end

    assign unused_pixel_bits = ^{pixel_in[11], pixel_in[6:5], pixel_in[0]};

endmodule

// File: tb/tb_vga_scanout_controller.sv
// Directed bench: a full-size instance checks line-level addressing/sync,
// a shrunken-timing instance checks frame-level swap and reset behaviour.
module tb_vga_scanout_controller;

    localparam int SH_ACT = 16, SH_FP = 2, SH_SYNC = 4, SH_BP = 2;
    localparam int SV_ACT = 12, SV_FP = 2, SV_SYNC = 2, SV_BP = 3;
    localparam int ST_H = SH_ACT + SH_FP + SH_SYNC + SH_BP;
    localparam int ST_V = SV_ACT + SV_FP + SV_SYNC + SV_BP;
    localparam int S_FRAME = ST_H * ST_V;
    localparam int S_SWAP_K = SV_ACT * ST_H;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, swap_req;
    logic [15:0] pixel;
    logic [16:0] read_addr;
    logic        display_buffer, swap_ack, frame_start;
    logic        vga_hsync, vga_vsync, vga_de;
    logic [3:0]  vga_r, vga_g, vga_b;

    logic        f_reset, f_swap_req;
    logic [15:0] f_pixel;
    logic [16:0] f_read_addr;
    logic        f_display_buffer, f_swap_ack, f_frame_start;
    logic        f_hsync, f_vsync, f_de;
    logic [3:0]  f_r, f_g, f_b;

    int n_checks = 0;
    int n_fail = 0;
    int k = 0;

    vga_scanout_controller #(
        .H_ACTIVE(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
        .V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP), .RD_LAT(1)
    ) dut (
        .clk(clk), .reset(reset), .swap_req(swap_req), .pixel_in(pixel),
        .read_addr(read_addr), .display_buffer(display_buffer), .swap_ack(swap_ack),
        .frame_start(frame_start), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_de(vga_de), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    vga_scanout_controller dut_full (
        .clk(clk), .reset(f_reset), .swap_req(f_swap_req), .pixel_in(f_pixel),
        .read_addr(f_read_addr), .display_buffer(f_display_buffer), .swap_ack(f_swap_ack),
        .frame_start(f_frame_start), .vga_hsync(f_hsync), .vga_vsync(f_vsync),
        .vga_de(f_de), .vga_r(f_r), .vga_g(f_g), .vga_b(f_b)
    );

    // c is the counter position (cycles since release); negative means still in reset.
    function automatic logic [16:0] exp_addr(int c, int ha, int ht, int va, int vt);
        int h, v;
        if (c < 0) return 17'd0;
        h = c % ht;
        v = (c / ht) % vt;
        if (h < ha && v < va) return 17'((v / 2) * 320 + h / 2);
        return 17'd0;
    endfunction

    function automatic logic [2:0] exp_ctl(int c, int ha, int hfp, int hs, int hbp,
                                           int va, int vfp, int vs, int vbp);
        int ht, vt, h, v;
        logic hsn, vsn, de;
        if (c < 0) return 3'b110;
        ht  = ha + hfp + hs + hbp;
        vt  = va + vfp + vs + vbp;
        h   = c % ht;
        v   = (c / ht) % vt;
        de  = (h < ha) && (v < va);
        hsn = !((h >= ha + hfp) && (h < ha + hfp + hs));
        vsn = !((v >= va + vfp) && (v < va + vfp + vs));
        return {hsn, vsn, de};
    endfunction

    task automatic tick();
        @(negedge clk);
        k++;
    endtask

    task automatic go_to(input int target);
        while (k < target) tick();
    endtask

    task automatic test_address();
        logic [2:0]  ctl;
        logic [16:0] ea;
        int          hs_low;
        hs_low = 0;
        f_reset = 1'b1;
        f_swap_req = 1'b0;
        f_pixel = 16'hF81F;
        repeat (3) @(negedge clk);
        f_reset = 1'b0;
        #1;
        n_checks++;
        if (f_frame_start !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL full_frame_start: got %b expected 1", f_frame_start);
        end
        for (int kf = 1; kf <= 1700; kf++) begin
            @(negedge clk);
            ea = exp_addr(kf - 1, 640, 800, 480, 525);
            n_checks++;
            if (f_read_addr !== ea) begin
                n_fail++;
                $display("[TB] FAIL full_addr k=%0d: got %0d expected %0d", kf, f_read_addr, ea);
            end
            ctl = exp_ctl(kf - 3, 640, 16, 96, 48, 480, 10, 2, 33);
            n_checks++;
            if ({f_hsync, f_vsync, f_de} !== ctl) begin
                n_fail++;
                $display("[TB] FAIL full_sync k=%0d: got %b expected %b", kf, {f_hsync, f_vsync, f_de}, ctl);
            end
            n_checks++;
            if ({f_r, f_g, f_b} !== (ctl[0] ? 12'hF0F : 12'h000)) begin
                n_fail++;
                $display("[TB] FAIL full_colour k=%0d: got %h expected %h", kf, {f_r, f_g, f_b}, ctl[0] ? 12'hF0F : 12'h000);
            end
            n_checks++;
            if ({f_frame_start, f_swap_ack, f_display_buffer} !== 3'b000) begin
                n_fail++;
                $display("[TB] FAIL full_flags k=%0d: got %b expected 000", kf, {f_frame_start, f_swap_ack, f_display_buffer});
            end
            if (kf >= 3 && kf < 803 && f_hsync === 1'b0) hs_low++;
        end
        n_checks++;
        if (hs_low != 96) begin
            n_fail++;
            $display("[TB] FAIL full_hsync_width: got %0d expected 96", hs_low);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        swap_req = 1'b1;
        pixel = 16'hF81F;
        repeat (5) begin
            @(negedge clk);
            n_checks++;
            if ({vga_hsync, vga_vsync, vga_de, display_buffer, swap_ack, frame_start, read_addr, vga_r, vga_g, vga_b}
                !== {6'b110000, 17'd0, 12'h000}) begin
                n_fail++;
                $display("[TB] FAIL reset_values: got hs=%b vs=%b de=%b db=%b ack=%b fs=%b addr=%0d rgb=%h expected 1 1 0 0 0 0 0 000",
                         vga_hsync, vga_vsync, vga_de, display_buffer, swap_ack, frame_start, read_addr, {vga_r, vga_g, vga_b});
            end
        end
        reset = 1'b0;
        swap_req = 1'b0;
        k = 0;
        #1;
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_release_frame_start: got %b expected 1", frame_start);
        end
    endtask

    task automatic test_sync_de();
        logic [2:0]  ctl;
        logic [16:0] ea;
        int de_cnt, vs_cnt, ack_cnt;
        de_cnt = 0;
        vs_cnt = 0;
        ack_cnt = 0;
        for (int i = 0; i < S_FRAME + 3; i++) begin
            tick();
            ctl = exp_ctl(k - 3, SH_ACT, SH_FP, SH_SYNC, SH_BP, SV_ACT, SV_FP, SV_SYNC, SV_BP);
            n_checks++;
            if ({vga_hsync, vga_vsync, vga_de} !== ctl) begin
                n_fail++;
                $display("[TB] FAIL sync_de k=%0d: got %b expected %b", k, {vga_hsync, vga_vsync, vga_de}, ctl);
            end
            n_checks++;
            if ({vga_r, vga_g, vga_b} !== (ctl[0] ? 12'hF0F : 12'h000)) begin
                n_fail++;
                $display("[TB] FAIL colour k=%0d: got %h expected %h", k, {vga_r, vga_g, vga_b}, ctl[0] ? 12'hF0F : 12'h000);
            end
            ea = exp_addr(k - 1, SH_ACT, ST_H, SV_ACT, ST_V);
            n_checks++;
            if (read_addr !== ea) begin
                n_fail++;
                $display("[TB] FAIL addr k=%0d: got %0d expected %0d", k, read_addr, ea);
            end
            n_checks++;
            if (frame_start !== (k % S_FRAME == 0)) begin
                n_fail++;
                $display("[TB] FAIL frame_start k=%0d: got %b expected %b", k, frame_start, (k % S_FRAME == 0));
            end
            if (k >= 3 && k < S_FRAME + 3) begin
                if (vga_de === 1'b1) de_cnt++;
                if (vga_vsync === 1'b0) vs_cnt++;
            end
            if (swap_ack === 1'b1) ack_cnt++;
        end
        n_checks++;
        if (de_cnt != SH_ACT * SV_ACT) begin
            n_fail++;
            $display("[TB] FAIL de_count: got %0d expected %0d", de_cnt, SH_ACT * SV_ACT);
        end
        n_checks++;
        if (vs_cnt != SV_SYNC * ST_H) begin
            n_fail++;
            $display("[TB] FAIL vsync_count: got %0d expected %0d", vs_cnt, SV_SYNC * ST_H);
        end
        n_checks++;
        if (ack_cnt != 0 || display_buffer !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL no_swap_from_reset_req: got acks=%0d db=%b expected 0 0", ack_cnt, display_buffer);
        end
    endtask

    task automatic test_colour();
        pixel = 16'h07E0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if ({vga_de, vga_r, vga_g, vga_b} !== {1'b1, 12'h0F0}) begin
                n_fail++;
                $display("[TB] FAIL colour_green k=%0d: got de=%b rgb=%h expected 1 0f0", k, vga_de, {vga_r, vga_g, vga_b});
            end
        end
        pixel = 16'hF81F;
    endtask

    task automatic test_swap();
        int ack_cnt, ack_k;
        ack_cnt = 0;
        ack_k = -1;
        go_to(S_FRAME + 3 * ST_H + 10);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        go_to(S_FRAME + 7 * ST_H + 20);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        while (k < 2 * S_FRAME + S_SWAP_K + 12) begin
            tick();
            if (swap_ack === 1'b1) begin
                ack_cnt++;
                ack_k = k;
            end
            if (k == S_FRAME + S_SWAP_K) begin
                n_checks++;
                if (display_buffer !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL swap_early: got db=%b expected 0", display_buffer);
                end
            end
            if (k == S_FRAME + S_SWAP_K + 1) begin
                n_checks++;
                if ({display_buffer, swap_ack} !== 2'b11) begin
                    n_fail++;
                    $display("[TB] FAIL swap_apply: got db/ack=%b expected 11", {display_buffer, swap_ack});
                end
            end
        end
        n_checks++;
        if (ack_cnt != 1 || ack_k != S_FRAME + S_SWAP_K + 1) begin
            n_fail++;
            $display("[TB] FAIL swap_ack_count: got %0d pulses last at k=%0d expected 1 at k=%0d",
                     ack_cnt, ack_k, S_FRAME + S_SWAP_K + 1);
        end
        n_checks++;
        if (display_buffer !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL swap_next_frame: got db=%b expected 1", display_buffer);
        end
    endtask

    task automatic test_midframe_reset();
        int ack_cnt;
        ack_cnt = 0;
        go_to(3 * S_FRAME + 4 * ST_H + 2);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        go_to(3 * S_FRAME + 6 * ST_H + 5);
        reset = 1'b1;
        repeat (2) begin
            tick();
            n_checks++;
            if ({vga_hsync, vga_vsync, vga_de, display_buffer, swap_ack, frame_start, read_addr, vga_r, vga_g, vga_b}
                !== {6'b110000, 17'd0, 12'h000}) begin
                n_fail++;
                $display("[TB] FAIL midframe_reset_values: got hs=%b vs=%b de=%b db=%b ack=%b fs=%b addr=%0d rgb=%h expected 1 1 0 0 0 0 0 000",
                         vga_hsync, vga_vsync, vga_de, display_buffer, swap_ack, frame_start, read_addr, {vga_r, vga_g, vga_b});
            end
        end
        reset = 1'b0;
        k = 0;
        #1;
        n_checks++;
        if (frame_start !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midframe_frame_start: got %b expected 1", frame_start);
        end
        while (k < S_SWAP_K + 12) begin
            tick();
            if (swap_ack === 1'b1) ack_cnt++;
        end
        n_checks++;
        if (ack_cnt != 0 || display_buffer !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL pending_dropped: got acks=%0d db=%b expected 0 0", ack_cnt, display_buffer);
        end
    endtask

    task automatic test_simultaneous_swap();
        go_to(S_FRAME + S_SWAP_K);
        n_checks++;
        if ({display_buffer, swap_ack} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL simul_before: got db/ack=%b expected 00", {display_buffer, swap_ack});
        end
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        n_checks++;
        if ({display_buffer, swap_ack} !== 2'b11) begin
            n_fail++;
            $display("[TB] FAIL simul_apply: got db/ack=%b expected 11", {display_buffer, swap_ack});
        end
        tick();
        n_checks++;
        if ({display_buffer, swap_ack} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL simul_ack_width: got db/ack=%b expected 10", {display_buffer, swap_ack});
        end
    endtask

    initial begin
        reset = 1'b1;
        swap_req = 1'b0;
        pixel = 16'hF81F;
        test_address();
        test_reset();
        test_sync_de();
        test_colour();
        test_swap();
        test_midframe_reset();
        test_simultaneous_swap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
